i2c_slave: RTL and testbench

I2C target-side controller: the responding end of the bus driven by the team's I2C master. It oversamples SCL/SDA on the system clock and detects START/STOP. It matches a 7-bit address, ACKs, then either receives bytes (master write) or shifts out bytes (master read). It sits between the pad-level open-drain SDA/SCL and a simple byte interface to local logic. SCL stretching is not supported.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_line_sync.sv | 52 +++++
 rtl/i2c_slave.sv | 185 ++++++++++++++++++
 tb/tb_i2c_slave.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C types and constants for target and master
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } i2c_slave_state_t;

    // Address byte layout on the wire: 7 address bits MSB first, then R/W.
    function automatic logic addr_hit(input logic [I2C_DATA_W-1:0] addr_rw,
                                      input logic [I2C_ADDR_W-1:0] addr);
        return addr_rw[I2C_DATA_W-1:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizer with edge, START and STOP detection
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl;

    assign scl = scl_sync_q[SYNC_STAGES-1];
    assign sda = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl;
        sda_prev_d = sda;
    end

    // Flops reset to 1 so a released bus looks idle and no edge fires out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise = scl & ~scl_prev_q;
    assign scl_fall = ~scl & scl_prev_q;
    assign start    = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop     = scl & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target: address match, byte receive and byte transmit
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h6B,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_DATA_W-1:0] tx_data,
    output logic                  tx_req,
    output logic                  addr_match,
    output logic                  busy
);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start_det),
        .stop     (stop_det)
    );

    i2c_slave_state_t        state_q, state_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [I2C_DATA_W-1:0]   shift_q, shift_d;
    logic                    rw_q, rw_d;
    logic                    sda_oe_q, sda_oe_d;
    logic [I2C_DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    addr_match_q, addr_match_d;
    logic                    busy_q, busy_d;
    logic                    load_tx;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        sda_oe_d     = sda_oe_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        addr_match_d = addr_match_q;
        busy_d       = busy_q;
        load_tx      = 1'b0;

        if (start_det) begin
            state_d      = ADDR;
            bit_cnt_d    = 4'd0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
        end else if (stop_det) begin
            state_d      = IDLE;
            bit_cnt_d    = 4'd0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, WR_BYTE: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[I2C_DATA_W-2:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ADDR) begin
                            if (addr_hit(shift_q, SLAVE_ADDR)) begin
                                state_d      = ADDR_ACK;
                                sda_oe_d     = 1'b1;
                                addr_match_d = 1'b1;
                                rw_d         = shift_q[0];
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end else begin
                            state_d    = WR_ACK;
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_oe_d   = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q == I2C_RW_READ) begin
                            load_tx = 1'b1;
                        end else begin
                            state_d   = WR_BYTE;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_d   = WR_BYTE;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                end
                RD_BYTE: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = RD_ACK;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                        end else begin
                            shift_d  = {shift_q[I2C_DATA_W-2:0], 1'b0};
                            sda_oe_d = ~shift_q[I2C_DATA_W-2];
                        end
                    end
                end
                RD_ACK: begin
                    // A NACK leaves immediately; reaching the next fall means the master ACKed.
                    if (scl_rise && sda) begin
                        state_d = WAIT_STOP;
                    end else if (scl_fall) begin
                        load_tx = 1'b1;
                    end
                end
                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end

        if (load_tx) begin
            state_d   = RD_BYTE;
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[I2C_DATA_W-1];
            bit_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            rw_q         <= I2C_RW_WRITE;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            sda_oe_q     <= sda_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_req     = load_tx;
    assign addr_match = addr_match_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - self-checking bench for i2c_slave with a behavioural bus master
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       addr_match;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_exp[$];
    logic [7:0] rx_obs[$];
    logic [7:0] rd_exp[$];
    logic [7:0] tx_src[$];
    int         tx_cnt     = 0;
    logic       oe_seen    = 1'b0;
    logic       tx_pending = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_m),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .addr_match (addr_match),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Observer: records received bytes, counts tx_req cycles, feeds the next tx byte afterwards.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (rx_valid) rx_obs.push_back(rx_data);
        if (tx_req) begin
            tx_cnt++;
            tx_pending = 1'b1;
        end else if (tx_pending) begin
            tx_pending = 1'b0;
            if (tx_src.size() > 0) tx_data = tx_src.pop_front();
        end
    end

    task automatic clock_bit(input logic b, output logic line, output logic oe);
        sda_m = b;
        #Q;
        scl_m = 1'b1;
        #Q;
        line = sda_line;
        oe   = sda_oe;
        #Q;
        scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        #Q;
        scl_m = 1'b1;
        #Q;
        sda_m = 1'b0;
        #Q;
        scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        #Q;
        scl_m = 1'b1;
        #Q;
        sda_m = 1'b1;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack_line, output logic ack_oe);
        logic l, o;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], l, o);
        clock_bit(1'b1, ack_line, ack_oe);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d, output logic ack_oe);
        logic l, o;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, l, o);
            d = {d[6:0], l};
        end
        clock_bit(~mack, l, ack_oe);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({sda_oe, rx_valid, tx_req, addr_match, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {sda_oe, rx_valid, tx_req, addr_match, busy});
        end
        total++;
        if (rx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_rx_data: got %h want 00", rx_data);
        end
        total++;
        if (dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        logic l, o;
        rx_obs.delete();
        rx_exp.push_back(8'h33);
        bus_start();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL write_busy: got %b want 1", busy); end
        send_byte(8'hD6, l, o);
        total++;
        if ({l, o} !== 2'b01) begin bad++; $display("FAIL write_addr_ack: got line=%b oe=%b want line=0 oe=1", l, o); end
        total++;
        if (addr_match !== 1'b1) begin bad++; $display("FAIL write_addr_match: got %b want 1", addr_match); end
        send_byte(8'h33, l, o);
        total++;
        if ({l, o} !== 2'b01) begin bad++; $display("FAIL write_data_ack: got line=%b oe=%b want line=0 oe=1", l, o); end
        bus_stop();
        total++;
        if ({busy, addr_match} !== 2'b00) begin bad++; $display("FAIL write_after_stop: got busy/match=%b want 00", {busy, addr_match}); end
        total++;
        if (rx_obs.size() != rx_exp.size()) begin bad++; $display("FAIL write_rx_count: got %0d want %0d", rx_obs.size(), rx_exp.size()); end
        while (rx_exp.size() > 0 && rx_obs.size() > 0) begin
            logic [7:0] e, a;
            e = rx_exp.pop_front();
            a = rx_obs.pop_front();
            total++;
            if (a !== e) begin bad++; $display("FAIL write_rx_data: got %h want %h", a, e); end
        end
        rx_exp.delete();
    endtask

    task automatic test_addr_miss();
        logic l, o;
        rx_obs.delete();
        bus_start();
        oe_seen = 1'b0;
        send_byte(8'h54, l, o);
        total++;
        if (l !== 1'b1) begin bad++; $display("FAIL miss_addr_nack: got line=%b want 1", l); end
        send_byte(8'hFF, l, o);
        total++;
        if (oe_seen !== 1'b0) begin bad++; $display("FAIL miss_sda_oe: got seen=%b want 0", oe_seen); end
        total++;
        if (rx_obs.size() != 0) begin bad++; $display("FAIL miss_rx_valid: got %0d want 0", rx_obs.size()); end
        total++;
        if (dut.state_q !== WAIT_STOP || busy !== 1'b1) begin
            bad++;
            $display("FAIL miss_wait_stop: got state=%0d busy=%b want state=%0d busy=1", dut.state_q, busy, WAIT_STOP);
        end
        bus_stop();
        total++;
        if (dut.state_q !== IDLE) begin bad++; $display("FAIL miss_idle: got %0d want %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_read();
        logic l, o;
        logic [7:0] d, e;
        tx_cnt = 0;
        tx_data = 8'hA5;
        tx_src.push_back(8'h5A);
        rd_exp.push_back(8'hA5);
        rd_exp.push_back(8'h5A);
        bus_start();
        send_byte(8'hD7, l, o);
        total++;
        if ({l, o} !== 2'b01) begin bad++; $display("FAIL read_addr_ack: got line=%b oe=%b want line=0 oe=1", l, o); end
        recv_byte(1'b1, d, o);
        e = rd_exp.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL read_byte1: got %h want %h", d, e); end
        total++;
        if (o !== 1'b0) begin bad++; $display("FAIL read_ack1_oe: got %b want 0", o); end
        recv_byte(1'b0, d, o);
        e = rd_exp.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL read_byte2: got %h want %h", d, e); end
        total++;
        if (o !== 1'b0) begin bad++; $display("FAIL read_nack_oe: got %b want 0", o); end
        total++;
        if (dut.state_q !== WAIT_STOP || sda_oe !== 1'b0) begin
            bad++;
            $display("FAIL read_after_nack: got state=%0d oe=%b want state=%0d oe=0", dut.state_q, sda_oe, WAIT_STOP);
        end
        bus_stop();
        total++;
        if (tx_cnt != 2) begin bad++; $display("FAIL read_tx_req: got %0d want 2", tx_cnt); end
    endtask

    task automatic test_repeated_start();
        logic l, o;
        logic [7:0] d;
        rx_obs.delete();
        tx_data = 8'h3C;
        bus_start();
        send_byte(8'hD6, l, o);
        for (int i = 0; i < 4; i++) clock_bit(i[0], l, o);
        bus_start();
        send_byte(8'hD7, l, o);
        total++;
        if ({l, o} !== 2'b01) begin bad++; $display("FAIL rs_addr_ack: got line=%b oe=%b want line=0 oe=1", l, o); end
        total++;
        if (addr_match !== 1'b1) begin bad++; $display("FAIL rs_addr_match: got %b want 1", addr_match); end
        recv_byte(1'b0, d, o);
        total++;
        if (d !== 8'h3C) begin bad++; $display("FAIL rs_read_byte: got %h want 3c", d); end
        bus_stop();
        total++;
        if (rx_obs.size() != 0) begin bad++; $display("FAIL rs_rx_valid: got %0d want 0", rx_obs.size()); end
    endtask

    task automatic test_reset_mid_byte();
        logic l, o;
        rx_obs.delete();
        bus_start();
        send_byte(8'hD6, l, o);
        for (int i = 0; i < 4; i++) clock_bit(1'b0, l, o);
        sda_m = 1'b1;
        #Q;
        scl_m = 1'b1;
        #20;
        reset = 1'b1;
        #10;
        total++;
        if ({sda_oe, rx_valid, tx_req, addr_match, busy} !== 5'b0 || rx_data !== 8'h00) begin
            bad++;
            $display("FAIL midreset_outputs: got ctrl=%b rx=%h want ctrl=00000 rx=00",
                     {sda_oe, rx_valid, tx_req, addr_match, busy}, rx_data);
        end
        #10;
        reset = 1'b0;
        #(Q - 20);
        scl_m = 1'b0;
        #Q;
        rx_exp.push_back(8'h81);
        bus_start();
        send_byte(8'hD6, l, o);
        send_byte(8'h81, l, o);
        total++;
        if ({l, o} !== 2'b01) begin bad++; $display("FAIL midreset_data_ack: got line=%b oe=%b want line=0 oe=1", l, o); end
        bus_stop();
        total++;
        if (rx_obs.size() != rx_exp.size()) begin bad++; $display("FAIL midreset_rx_count: got %0d want %0d", rx_obs.size(), rx_exp.size()); end
        while (rx_exp.size() > 0 && rx_obs.size() > 0) begin
            logic [7:0] e, a;
            e = rx_exp.pop_front();
            a = rx_obs.pop_front();
            total++;
            if (a !== e) begin bad++; $display("FAIL midreset_rx_data: got %h want %h", a, e); end
        end
        rx_exp.delete();
    endtask

    task automatic test_back_to_back();
        logic l, o;
        logic [7:0] bytes [3];
        bytes[0] = 8'h01;
        bytes[1] = 8'h02;
        bytes[2] = 8'h03;
        rx_obs.delete();
        bus_start();
        send_byte(8'hD6, l, o);
        for (int i = 0; i < 3; i++) begin
            rx_exp.push_back(bytes[i]);
            send_byte(bytes[i], l, o);
            total++;
            if ({l, o} !== 2'b01) begin bad++; $display("FAIL b2b_ack%0d: got line=%b oe=%b want line=0 oe=1", i, l, o); end
        end
        bus_stop();
        total++;
        if (rx_obs.size() != rx_exp.size()) begin bad++; $display("FAIL b2b_rx_count: got %0d want %0d", rx_obs.size(), rx_exp.size()); end
        while (rx_exp.size() > 0 && rx_obs.size() > 0) begin
            logic [7:0] e, a;
            e = rx_exp.pop_front();
            a = rx_obs.pop_front();
            total++;
            if (a !== e) begin bad++; $display("FAIL b2b_rx_data: got %h want %h", a, e); end
        end
        rx_exp.delete();
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_miss();
        test_read();
        test_repeated_start();
        test_reset_mid_byte();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
